reg_sel_sequencer: RTL and testbench



---
 rtl/reg_sel_pkg.sv | 28 ++
 rtl/reg_sel_sequencer_if.sv | 29 ++
 rtl/reg_sel_addr_mux.sv | 41 ++++
 rtl/reg_sel_sequencer.sv | 135 +++++++++++++
 tb/tb_reg_sel_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_sel_pkg.sv
// Shared types for the register-select family: select codes, sequencer FSM
// states, default register indices and the burst length clamp helper.
package reg_sel_pkg;

    localparam int ACC_REG_DEF = 15;
    localparam int FB_REG_DEF  = 13;

    typedef enum logic [2:0] {
        SEL_ACC   = 3'd0,
        SEL_FB    = 3'd1,
        SEL_FIELD = 3'd2,
        SEL_BURST = 3'd3
    } reg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_BURST
    } state_e;

    // A zero length still produces one beat; anything past the limit is clamped.
    function automatic int unsigned burst_beats(input int unsigned len, input int unsigned max_burst);
        if (len == 0) return 1;
        if (len > max_burst) return max_burst;
        return len;
    endfunction

endpackage

// File: rtl/reg_sel_sequencer_if.sv
// Request/response bundle between the control unit (master) and the
// register-select sequencer (slave).
interface reg_sel_sequencer_if #(
    parameter int REG_ADDR_W = 4,
    parameter int INSTR_W    = 9,
    parameter int CNT_W      = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            sel;
    logic [INSTR_W-1:0]    instr;
    logic [CNT_W-1:0]      burst_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic                  out_last;
    logic                  busy;
    logic                  err;

    modport slave (
        input  in_valid, sel, instr, burst_len, out_ready,
        output in_ready, out_valid, reg_addr, out_last, busy, err
    );

    modport master (
        output in_valid, sel, instr, burst_len, out_ready,
        input  in_ready, out_valid, reg_addr, out_last, busy, err
    );
endinterface

// File: rtl/reg_sel_addr_mux.sv
// Combinational select-code/instruction to base register address resolution.
// Shared by the reg1 sequencer and the future reg2 selector.
module reg_sel_addr_mux
    import reg_sel_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int ACC_REG    = ACC_REG_DEF,
    parameter int FB_REG     = FB_REG_DEF,
    parameter int INSTR_W    = 9,
    parameter int FIELD_LSB  = 3,
    parameter int FIELD_W    = 3
) (
    input  logic [2:0]            sel_i,
    input  logic [INSTR_W-1:0]    instr_i,
    output logic [REG_ADDR_W-1:0] addr_o,
    output logic                  burst_o,
    output logic                  invalid_o
);
    logic [FIELD_W-1:0] field;
    logic               unused_instr;

    assign field        = instr_i[FIELD_LSB +: FIELD_W];
    assign unused_instr = ^instr_i;

    // Invalid codes fall back to the accumulator so the caller always has an address.
    always_comb begin
        addr_o    = REG_ADDR_W'(ACC_REG);
        burst_o   = 1'b0;
        invalid_o = 1'b0;
        case (sel_i)
            SEL_ACC:   addr_o = REG_ADDR_W'(ACC_REG);
            SEL_FB:    addr_o = REG_ADDR_W'(FB_REG);
            SEL_FIELD: addr_o = REG_ADDR_W'(field);
            SEL_BURST: begin
                addr_o  = REG_ADDR_W'(field);
                burst_o = 1'b1;
            end
            default:   invalid_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/reg_sel_sequencer.sv
// Register-file read address sequencer: single beats or bursts of consecutive
// addresses with valid/ready on both sides. ERR_TRAP_EN turns an invalid select into a halt.
module reg_sel_sequencer
    import reg_sel_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int ACC_REG    = ACC_REG_DEF,
    parameter int FB_REG     = FB_REG_DEF,
    parameter int INSTR_W    = 9,
    parameter int FIELD_LSB  = 3,
    parameter int FIELD_W    = 3,
    parameter int MAX_BURST  = 8
) (
    input logic clk,
    input logic reset,
    reg_sel_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  in_ready;
    logic                  accept;
    logic [31:0]           beats;
    logic [REG_ADDR_W-1:0] mux_addr;
    logic                  mux_burst;
    logic                  mux_invalid;

    reg_sel_addr_mux #(
        .REG_ADDR_W (REG_ADDR_W),
        .ACC_REG    (ACC_REG),
        .FB_REG     (FB_REG),
        .INSTR_W    (INSTR_W),
        .FIELD_LSB  (FIELD_LSB),
        .FIELD_W    (FIELD_W)
    ) u_mux (
        .sel_i     (bus.sel),
        .instr_i   (bus.instr),
        .addr_o    (mux_addr),
        .burst_o   (mux_burst),
        .invalid_o (mux_invalid)
    );

`ifdef ERR_TRAP_EN
    logic halt_q, halt_d;
    assign in_ready = ((state_q == ST_IDLE) || ((state_q == ST_EMIT) && bus.out_ready)) && !halt_q;
`else
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_EMIT) && bus.out_ready);
`endif

    assign accept = bus.in_valid && in_ready;
    assign beats  = burst_beats(32'(bus.burst_len), MAX_BURST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef ERR_TRAP_EN
        halt_d  = halt_q;
`endif
        // cnt_q counts beats still to come after the one currently presented.
        case (state_q)
            ST_EMIT: if (bus.out_ready) state_d = ST_IDLE;
            ST_BURST: begin
                if (bus.out_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = addr_q + REG_ADDR_W'(1);
                        cnt_d  = cnt_q - CNT_W'(1);
                        last_d = (cnt_q == CNT_W'(1));
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (mux_invalid) begin
                err_d = 1'b1;
`ifdef ERR_TRAP_EN
                halt_d  = 1'b1;
                state_d = ST_IDLE;
`else
                state_d = ST_EMIT;
                addr_d  = mux_addr;
                last_d  = 1'b1;
`endif
            end else if (mux_burst) begin
                state_d = ST_BURST;
                addr_d  = mux_addr;
                cnt_d   = CNT_W'(beats - 32'd1);
                last_d  = (beats == 32'd1);
            end else begin
                state_d = ST_EMIT;
                addr_d  = mux_addr;
                last_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= REG_ADDR_W'(ACC_REG);
            last_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef ERR_TRAP_EN
            halt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef ERR_TRAP_EN
            halt_q  <= halt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != ST_IDLE);
    assign bus.reg_addr  = addr_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = (state_q == ST_BURST);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_reg_sel_sequencer.sv
// Bench for reg_sel_sequencer: vector table, hand-built burst corner cases and
// randomized traffic against a beat-queue reference model. Honours ERR_TRAP_EN.
module tb_reg_sel_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    reg_sel_sequencer_if #(.REG_ADDR_W(4), .INSTR_W(9), .CNT_W(4)) bus ();
    reg_sel_sequencer_if #(.REG_ADDR_W(3), .INSTR_W(9), .CNT_W(4)) bus_w ();

    reg_sel_sequencer u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    reg_sel_sequencer #(.REG_ADDR_W(3), .ACC_REG(7), .FB_REG(5)) u_dut_w (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_w.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are read 1 time unit later.
    task automatic drv(input logic r, input logic iv, input logic [2:0] s,
                       input logic [8:0] ins, input logic [3:0] len, input logic ordy);
        @(negedge clk);
        rst = r;
        bus.in_valid    = iv;  bus_w.in_valid  = iv;
        bus.sel         = s;   bus_w.sel       = s;
        bus.instr       = ins; bus_w.instr     = ins;
        bus.burst_len   = len; bus_w.burst_len = len;
        bus.out_ready   = ordy; bus_w.out_ready = ordy;
        #1;
    endtask

    typedef struct {
        logic       iv;
        logic [2:0] sel;
        logic [8:0] instr;
        logic [3:0] len;
        logic       ev;
        int         ea;
        logic       el;
        logic       eb;
        logic       eir;
    } vec_t;

    vec_t vecs[15];

    typedef struct {
        int addr;
        bit last;
        bit burst;
    } beat_t;

    beat_t exp_q[$];
    int    m_last_addr;
    bit    m_err, m_halt;

    function automatic bit m_in_ready(input bit ordy);
        return !m_halt && (exp_q.size() == 0 ||
               (exp_q.size() == 1 && !exp_q[0].burst && ordy));
    endfunction

    initial begin
        int k;
        // Test-plan sequences with out_ready held at 1.
        vecs[0]  = '{1'b1, 3'd0, 9'd0,  4'd0, 1'b0, 15, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 3'd1, 9'd0,  4'd0, 1'b1, 15, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 3'd2, 9'd40, 4'd0, 1'b1, 13, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b1, 5,  1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b0, 5,  1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'd3, 9'd16, 4'd3, 1'b0, 5,  1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b1, 2,  1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b1, 3,  1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd0, 9'd0,  4'd0, 1'b1, 4,  1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'd0, 9'd0,  4'd0, 1'b0, 4,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b1, 15, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b0, 15, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 3'd3, 9'd56, 4'd0, 1'b0, 15, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b1, 7,  1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 9'd0,  4'd0, 1'b0, 7,  1'b0, 1'b0, 1'b1};

        drv(1, 0, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 1);
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_addr",  int'(bus.reg_addr), 15);
        chk("reset_last",  int'(bus.out_last), 0);
        chk("reset_busy",  int'(bus.busy), 0);
        chk("reset_err",   int'(bus.err), 0);

        for (int i = 0; i < 15; i++) begin
            drv(0, vecs[i].iv, vecs[i].sel, vecs[i].instr, vecs[i].len, 1);
            $display("vec %0d: valid=%0d addr=%0d last=%0d busy=%0d in_ready=%0d",
                     i, bus.out_valid, bus.reg_addr, bus.out_last, bus.busy, bus.in_ready);
            chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(vecs[i].ev));
            chk($sformatf("vec%0d_addr", i),  int'(bus.reg_addr),  vecs[i].ea);
            if (vecs[i].ev) chk($sformatf("vec%0d_last", i), int'(bus.out_last), int'(vecs[i].el));
            chk($sformatf("vec%0d_busy", i),  int'(bus.busy),      int'(vecs[i].eb));
            chk($sformatf("vec%0d_inrdy", i), int'(bus.in_ready),  int'(vecs[i].eir));
        end

        // burst_len 12 clamps to 8 beats: 7..14.
        drv(0, 1, 3, 9'd56, 4'd12, 1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            drv(0, 0, 0, 0, 0, 1);
            if (bus.out_valid) begin
                chk("b12_addr", int'(bus.reg_addr), 7 + k);
                chk("b12_last", int'(bus.out_last), int'(k == 7));
                k++;
            end else if (k > 0) break;
        end
        chk("b12_beats", k, 8);
        $display("burst len 12: %0d beats", k);

        // Stall beat 1 of a 5-beat burst for three cycles.
        drv(0, 1, 3, 9'd8, 4'd5, 1);
        k = 0;
        for (int i = 0; i < 30 && k < 5; i++) begin
            logic ordy;
            ordy = !(i >= 1 && i <= 3);
            drv(0, 0, 0, 0, 0, ordy);
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_addr",  int'(bus.reg_addr), 1 + k);
            chk("stall_last",  int'(bus.out_last), int'(k == 4));
            if (ordy) k++;
        end
        chk("stall_beats", k, 5);
        drv(0, 0, 0, 0, 0, 1);
        chk("stall_done", int'(bus.out_valid), 0);
        $display("stalled burst: %0d beats", k);

        // Reset presented while beat 2 of a 5-beat burst is on the bus.
        drv(0, 1, 3, 9'd0, 4'd5, 1);
        drv(0, 0, 0, 0, 0, 1);
        chk("rst_b0", int'(bus.reg_addr), 0);
        drv(0, 0, 0, 0, 0, 1);
        chk("rst_b1", int'(bus.reg_addr), 1);
        drv(1, 0, 0, 0, 0, 1);
        chk("rst_b2", int'(bus.reg_addr), 2);
        chk("rst_b2_busy", int'(bus.busy), 1);
        drv(0, 0, 0, 0, 0, 1);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_addr",  int'(bus.reg_addr), 15);
        chk("rst_inrdy", int'(bus.in_ready), 1);
        $display("reset mid-burst: valid=%0d addr=%0d", bus.out_valid, bus.reg_addr);

        // Wrap-around on the 3-bit instance: 7, 0, 1.
        drv(0, 1, 3, 9'd56, 4'd3, 1);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 1);
            chk("wrap_valid", int'(bus_w.out_valid), 1);
            chk("wrap_addr",  int'(bus_w.reg_addr), (7 + i) % 8);
            chk("wrap_last",  int'(bus_w.out_last), int'(i == 2));
        end
        drv(0, 0, 0, 0, 0, 1);
        chk("wrap_done", int'(bus_w.out_valid), 0);
        $display("wrap burst done: addr=%0d", bus_w.reg_addr);

        // Invalid select code 6.
        drv(0, 1, 6, 0, 0, 1);
        chk("inv_inrdy0", int'(bus.in_ready), 1);
        drv(0, 0, 0, 0, 0, 1);
        chk("inv_err", int'(bus.err), 1);
`ifdef ERR_TRAP_EN
        chk("trap_valid", int'(bus.out_valid), 0);
        chk("trap_inrdy", int'(bus.in_ready), 0);
        drv(0, 1, 1, 0, 0, 1);
        chk("trap_inrdy2", int'(bus.in_ready), 0);
        drv(0, 0, 0, 0, 0, 1);
        chk("trap_valid2", int'(bus.out_valid), 0);
        chk("trap_err2", int'(bus.err), 1);
`else
        chk("inv_valid", int'(bus.out_valid), 1);
        chk("inv_addr",  int'(bus.reg_addr), 15);
        chk("inv_last",  int'(bus.out_last), 1);
        drv(0, 1, 1, 0, 0, 1);
        chk("inv_inrdy", int'(bus.in_ready), 1);
        drv(0, 0, 0, 0, 0, 1);
        chk("inv_next_valid", int'(bus.out_valid), 1);
        chk("inv_next_addr",  int'(bus.reg_addr), 13);
        chk("inv_err_sticky", int'(bus.err), 1);
`endif
        drv(1, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 1);
        chk("inv_rst_err",   int'(bus.err), 0);
        chk("inv_rst_inrdy", int'(bus.in_ready), 1);
        $display("invalid sel: err cleared by reset");

        // Randomized traffic against the beat-queue model.
        for (int i = 0; i < 2400; i++) begin
            logic       r, iv, ordy;
            logic [2:0] s;
            logic [8:0] ins;
            logic [3:0] len;
            bool_blk: begin end
            r    = (i % 600 == 0) || ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 9) < 6);
            s    = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            ins  = 9'($urandom);
            len  = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 9) < 7);
            drv(r, iv, s, ins, len, ordy);
            if (i > 0) begin
                chk("rnd_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
                chk("rnd_addr",  int'(bus.reg_addr), exp_q.size() != 0 ? exp_q[0].addr : m_last_addr);
                if (exp_q.size() != 0) chk("rnd_last", int'(bus.out_last), int'(exp_q[0].last));
                chk("rnd_busy",  int'(bus.busy), int'(exp_q.size() != 0 && exp_q[0].burst));
                chk("rnd_err",   int'(bus.err), int'(m_err));
                chk("rnd_inrdy", int'(bus.in_ready), int'(m_in_ready(ordy)));
            end
            @(posedge clk);
            if (r) begin
                exp_q.delete();
                m_last_addr = 15;
                m_err  = 0;
                m_halt = 0;
            end else begin
                bit acc;
                int field, n;
                acc   = iv && m_in_ready(ordy);
                field = int'(ins[5:3]);
                if (exp_q.size() != 0 && ordy) begin
                    m_last_addr = exp_q[0].addr;
                    void'(exp_q.pop_front());
                end
                if (acc) begin
                    case (s)
                        3'd0: exp_q.push_back('{15, 1'b1, 1'b0});
                        3'd1: exp_q.push_back('{13, 1'b1, 1'b0});
                        3'd2: exp_q.push_back('{field, 1'b1, 1'b0});
                        3'd3: begin
                            n = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
                            for (int b = 0; b < n; b++)
                                exp_q.push_back('{(field + b) % 16, b == n - 1, 1'b1});
                        end
                        default: begin
                            m_err = 1;
`ifdef ERR_TRAP_EN
                            m_halt = 1;
`else
                            exp_q.push_back('{15, 1'b1, 1'b0});
`endif
                        end
                    endcase
                end
            end
        end
        $display("random traffic: 2400 cycles");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
